// File: rtl/top_pkg.sv
// Shared constants for the top-level 2:1 selector.
package top_pkg;

    // Default data width of the selector.
    localparam int unsigned TOP_N = 8;

    // Select encodings: SEL_A picks input a, SEL_B picks input b.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_bit.sv
// One-bit 2:1 multiplexer built from explicit AND/OR/NOT gates.
module mux2_bit (
    input  logic a,
    input  logic b,
    input  logic sel,
    input  logic unused_tie,
    output logic y
);

    logic sel_n;
    logic pick_a;
    logic pick_b;

    // y = (a & ~sel) | (b & sel), kept as discrete gates so the netlist stays explicit.
    not u_inv  (sel_n,  sel);
    and u_and_a(pick_a, a, sel_n);
    and u_and_b(pick_b, b, sel);
    or  u_or   (y,      pick_a, pick_b);

endmodule

// File: rtl/top_mux2.sv
// Registered, width-parameterised 2:1 data selector.
// Optional feature: define TOP_MUX2_SEL_SYNC_EN to route sel through a
// 2-flop synchronizer (sel-to-out latency 3 cycles, a/b-to-out stays 1).
module top_mux2
    import top_pkg::*;
#(
    parameter int unsigned N = TOP_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] out
);

    logic         sel_core;
    logic [N-1:0] m;

`ifdef TOP_MUX2_SEL_SYNC_EN
    logic sel_meta;
    logic sel_sync;

    // Two-stage synchronizer for a sel coming from another clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_meta <= SEL_A;
            sel_sync <= SEL_A;
        end else begin
            sel_meta <= sel;
            sel_sync <= sel_meta;
        end
    end

    assign sel_core = sel_sync;
`else
    assign sel_core = sel;
`endif

    // One gate-level slice per bit; bit i of m depends only on a[i] and b[i].
    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        mux2_bit u_bit (
            .a          (a[i]),
            .b          (b[i]),
            .sel        (sel_core),
            .unused_tie (1'b0),
            .y          (m[i])
        );
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= N'(0);
        end else begin
            out <= m;
        end
    end

endmodule

// File: tb/tb_top_mux2.sv
// Self-checking bench for top_mux2: directed cases followed by random traffic,
// compared against a behavioural model of "out = previous edge's selected input".
module tb_top_mux2;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] out;

    int checks   = 0;
    int failures = 0;

    // Sel values seen at past edges; the core uses the oldest when synchronized.
    logic sel_hist[$];

    top_mux2 #(.N(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] exp);
        checks++;
        assert (out === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, out, exp);
        end
    endtask

    // Drive one cycle of inputs, let an edge pass, then compare with the model.
    task automatic step(input string tag, input logic r, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic s);
        logic         eff;
        logic [W-1:0] exp;
        rst = r;
        a   = av;
        b   = bv;
        sel = s;
        @(posedge clk);
`ifdef TOP_MUX2_SEL_SYNC_EN
        eff = sel_hist[0];
        if (r) begin
            sel_hist = '{1'b0, 1'b0};
        end else begin
            void'(sel_hist.pop_front());
            sel_hist.push_back(s);
        end
`else
        eff = s;
`endif
        exp = r ? '0 : (eff ? bv : av);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic         rr;

        sel_hist = '{1'b0, 1'b0};
        rst = 1'b1;
        a   = '0;
        b   = '0;
        sel = 1'b0;

        // Reset held for two cycles with all-ones data, then release onto a = 00.
        step("rst_hold0", 1'b1, 8'hFF, 8'hFF, 1'b0);
        step("rst_hold1", 1'b1, 8'hFF, 8'hFF, 1'b1);
        step("rst_release", 1'b0, 8'h00, 8'hFF, 1'b0);

        // Basic selection.
        step("sel_a_zero", 1'b0, 8'h00, 8'h01, 1'b0);
        step("sel_a_one",  1'b0, 8'h01, 8'h02, 1'b0);
        step("sel_b_two",  1'b0, 8'h01, 8'h02, 1'b1);
        step("sel_b_hold0", 1'b0, 8'h01, 8'h02, 1'b1);
        step("sel_b_hold1", 1'b0, 8'h01, 8'h02, 1'b1);

        // sel toggling every cycle.
        for (int k = 0; k < 6; k++) begin
            step($sformatf("toggle%0d", k), 1'b0, 8'hA5, 8'h5A, 1'(k % 2));
        end

        // Walking one on a and b, different bit positions, under both selects.
        for (int i = 0; i < int'(W); i++) begin
            wa = W'(1) << i;
            wb = W'(1) << ((i + 1) % int'(W));
            step($sformatf("walk_a%0d", i), 1'b0, wa, wb, 1'b0);
            step($sformatf("walk_b%0d", i), 1'b0, wa, wb, 1'b1);
        end

        // Mid-stream reset from out = 5A, then resume.
        step("pre_rst0", 1'b0, 8'h5A, 8'hC3, 1'b0);
        step("pre_rst1", 1'b0, 8'h5A, 8'hC3, 1'b0);
        step("pre_rst2", 1'b0, 8'h5A, 8'hC3, 1'b0);
        step("mid_rst",  1'b1, 8'h5A, 8'hC3, 1'b0);
        step("post_rst0", 1'b0, 8'h3C, 8'hC3, 1'b0);
        step("post_rst1", 1'b0, 8'h3C, 8'hC3, 1'b1);

        // Random traffic; a/b glitch between edges to show only edge values matter.
        for (int k = 0; k < 300; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sel = 1'($urandom);
            #3;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            rr = ($urandom_range(0, 19) == 0);
            step($sformatf("rand%0d", k), rr, ra, rb, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
